// File: rtl/vec_chk_pkg.sv
// Shared types and helpers for the ISCAS85 response checker: FSM state encoding,
// default MISR constants and the response-folding function.
package vec_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [31:0] DEF_SIG_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] DEF_SIG_SEED = 32'hFFFF_FFFF;

  // Upper bounds for fold_xor; callers zero-extend their vector and truncate the result.
  localparam int FOLD_MAX_IN_W  = 1024;
  localparam int FOLD_MAX_SIG_W = 64;

  // Bit i lands in chunk bit (i mod sig_w): identical to XOR-ing zero-padded sig_w-bit chunks.
  function automatic logic [FOLD_MAX_SIG_W-1:0] fold_xor(input logic [FOLD_MAX_IN_W-1:0] vec,
                                                         input int                       sig_w);
    logic [FOLD_MAX_SIG_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < FOLD_MAX_IN_W; i++) begin
      acc[i % sig_w] = acc[i % sig_w] ^ vec[i];
    end
    return acc;
  endfunction

endpackage

// File: rtl/vec_misr.sv
// Multiple-input signature register: Galois shift with polynomial feedback, XOR-ing in
// one SIG_W-bit word per enabled cycle; load restores the seed.
module vec_misr
  import vec_chk_pkg::*;
#(
  parameter int               SIG_W    = 32,
  parameter logic [SIG_W-1:0] SIG_POLY = SIG_W'(DEF_SIG_POLY),
  parameter logic [SIG_W-1:0] SIG_SEED = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [SIG_W-1:0] din,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (load) begin
      sig_d = SIG_SEED;
    end else if (en) begin
      sig_d = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? SIG_POLY : '0) ^ din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) sig_q <= SIG_SEED;
    else        sig_q <= sig_d;
  end

  assign sig = sig_q;

endmodule

// File: rtl/vec_response_checker.sv
// Response end of the ISCAS85 vector flow: captures one DUT output per valid beat, compares it
// one cycle later with the expected-ROM word, counts mismatches and compacts responses into a MISR.
module vec_response_checker
  import vec_chk_pkg::*;
#(
  parameter int               OUT_WIDTH  = 123,
  parameter int               VEC_LENGTH = 8,
  parameter int               ADDR_W     = 3,
  parameter int               SIG_W      = 32,
  parameter logic [SIG_W-1:0] SIG_POLY   = SIG_W'(DEF_SIG_POLY),
  parameter logic [SIG_W-1:0] SIG_SEED   = '1,
  parameter int               CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 resp_valid,
  input  logic [OUT_WIDTH-1:0] resp_vec,
  output logic [ADDR_W-1:0]    exp_addr,
  input  logic [OUT_WIDTH-1:0] exp_vec,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CNT_W-1:0]     mismatch_cnt,
  output logic [ADDR_W-1:0]    first_fail_idx,
  output logic [SIG_W-1:0]     signature
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(VEC_LENGTH - 1);

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     idx_q, idx_d;
  logic                  cmp_v_q, cmp_v_d;
  logic [OUT_WIDTH-1:0]  resp_q, resp_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_W-1:0]     ffi_q, ffi_d;
  logic                  fail_seen_q, fail_seen_d;
  logic                  sig_load, sig_en;
  logic [SIG_W-1:0]      sig_din;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cmp_v_d     = 1'b0;
    resp_d      = resp_q;
    cnt_d       = cnt_q;
    ffi_d       = ffi_q;
    fail_seen_d = fail_seen_q;
    sig_load    = 1'b0;
    sig_en      = 1'b0;

    // idx has already advanced past the captured beat, hence idx-1 for its index.
    if (cmp_v_q) begin
      sig_en = 1'b1;
      if (resp_q != exp_vec) begin
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        if (!fail_seen_q) begin
          ffi_d       = idx_q - 1'b1;
          fail_seen_d = 1'b1;
        end
      end
    end

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_RUN;
          idx_d       = '0;
          cnt_d       = '0;
          ffi_d       = '0;
          fail_seen_d = 1'b0;
          sig_load    = 1'b1;
        end
      end
      ST_RUN: begin
        if (resp_valid) begin
          resp_d  = resp_vec;
          cmp_v_d = 1'b1;
          idx_d   = idx_q + 1'b1;
          if (idx_q == LAST_IDX) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      cmp_v_q     <= 1'b0;
      cnt_q       <= '0;
      ffi_q       <= '0;
      fail_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cmp_v_q     <= cmp_v_d;
      cnt_q       <= cnt_d;
      ffi_q       <= ffi_d;
      fail_seen_q <= fail_seen_d;
    end
  end

  // NOTE: resp_q is a wide datapath register left without reset; cmp_v_q qualifies every use of it.
  always_ff @(posedge clk) begin
    resp_q <= resp_d;
  end

  assign sig_din = SIG_W'(fold_xor(FOLD_MAX_IN_W'(resp_q), SIG_W));

  vec_misr #(
    .SIG_W   (SIG_W),
    .SIG_POLY(SIG_POLY),
    .SIG_SEED(SIG_SEED)
  ) u_misr (
    .clk  (clk),
    .rst_n(rst_n),
    .load (sig_load),
    .en   (sig_en),
    .din  (sig_din),
    .sig  (signature)
  );

  assign exp_addr       = idx_q;
  assign busy           = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done           = (state_q == ST_DONE);
  assign pass           = done && (cnt_q == '0);
  assign mismatch_cnt   = cnt_q;
  assign first_fail_idx = ffi_q;

endmodule

// File: tb/tb_vec_response_checker.sv
// Self-checking bench: random responses against a chunk-XOR / MISR reference model,
// plus a CNT_W=2 instance fed an always-wrong ROM to exercise counter saturation.
module tb_vec_response_checker;

  localparam int OW = 123;
  localparam int NV = 8;
  localparam logic [31:0] POLY = 32'h04C1_1DB7;
  localparam logic [31:0] SEED = 32'hFFFF_FFFF;

  logic          clk, rst_n, start, resp_valid;
  logic [OW-1:0] resp_vec, exp_vec_q, exp_vec_sat;
  logic [2:0]    exp_addr, sat_exp_addr, first_fail_idx, sat_ffi;
  logic          busy, done, pass, sat_busy, sat_done, sat_pass;
  logic [7:0]    mismatch_cnt;
  logic [1:0]    sat_cnt;
  logic [31:0]   signature, sat_sig;

  logic [OW-1:0] resp [NV];
  logic [OW-1:0] rom  [NV];

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] sig_ref;

  vec_response_checker u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .resp_valid(resp_valid), .resp_vec(resp_vec),
    .exp_addr(exp_addr), .exp_vec(exp_vec_q), .busy(busy), .done(done), .pass(pass),
    .mismatch_cnt(mismatch_cnt), .first_fail_idx(first_fail_idx), .signature(signature)
  );

  vec_response_checker #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .resp_valid(resp_valid), .resp_vec(resp_vec),
    .exp_addr(sat_exp_addr), .exp_vec(exp_vec_sat), .busy(sat_busy), .done(sat_done),
    .pass(sat_pass), .mismatch_cnt(sat_cnt), .first_fail_idx(sat_ffi), .signature(sat_sig)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected-vector ROM with one cycle of read latency.
  always @(posedge clk) exp_vec_q <= rom[exp_addr];
  assign exp_vec_sat = ~exp_vec_q;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [OW-1:0] rand_vec();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[OW-1:0];
  endfunction

  // Signature from the rule: zero-pad to 128 bits, XOR four 32-bit chunks, one Galois step per vector.
  function automatic logic [31:0] model_sig();
    logic [31:0] s;
    s = SEED;
    for (int v = 0; v < NV; v++) begin
      logic [127:0] p;
      logic [31:0]  f;
      p = 128'(resp[v]);
      f = p[31:0] ^ p[63:32] ^ p[95:64] ^ p[127:96];
      s = (s << 1) ^ (s[31] ? POLY : 32'd0) ^ f;
    end
    return s;
  endfunction

  task automatic check_results(input string tag);
    int n_bad, first;
    n_bad = 0;
    first = -1;
    for (int v = 0; v < NV; v++) begin
      if (resp[v] != rom[v]) begin
        n_bad++;
        if (first < 0) first = v;
      end
    end
    if (first < 0) first = 0;
    check({tag, ".cnt"},      128'(mismatch_cnt),   128'(n_bad > 255 ? 255 : n_bad));
    check({tag, ".ffi"},      128'(first_fail_idx), 128'(first));
    check({tag, ".pass"},     128'(pass),           128'(n_bad == 0));
    check({tag, ".sig"},      128'(signature),      128'(model_sig()));
    check({tag, ".sat_cnt"},  128'(sat_cnt),        128'(3));
    check({tag, ".sat_ffi"},  128'(sat_ffi),        128'(0));
    check({tag, ".sat_sig"},  128'(sat_sig),        128'(model_sig()));
  endtask

  // All drive tasks begin just after a negedge and return just after a later negedge.
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic beat(input int i, input bit pulse_start);
    resp_valid = 1'b1;
    resp_vec   = resp[i];
    start      = pulse_start;
    @(negedge clk);
    resp_valid = 1'b0;
    start      = 1'b0;
    resp_vec   = rand_vec();
  endtask

  task automatic run(input string tag, input int stalls, input int start_at);
    do_start();
    for (int i = 0; i < NV; i++) begin
      if (i > 0) begin
        for (int s = 0; s < stalls; s++) begin
          resp_valid = 1'b0;
          resp_vec   = rand_vec();
          @(negedge clk);
          check({tag, ".addr_hold"}, 128'(exp_addr), 128'(i));
        end
      end
      beat(i, i == start_at);
    end
    // Cycle after the last beat is DRAIN; done rises on the following edge.
    check({tag, ".drain_busy"}, 128'({busy, done}), 128'(2'b10));
    @(negedge clk);
    check({tag, ".done"}, 128'({busy, done}), 128'(2'b01));
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    resp_valid = 1'b0;
    resp_vec   = '0;
    for (int v = 0; v < NV; v++) begin
      resp[v] = rand_vec();
      rom[v]  = resp[v];
    end
    repeat (2) @(negedge clk);
    check("reset.flags", 128'({busy, done, pass}), 128'(3'b000));
    check("reset.cnt",   128'(mismatch_cnt),       128'(0));
    check("reset.ffi",   128'(first_fail_idx),     128'(0));
    check("reset.sig",   128'(signature),          128'(SEED));
    check("reset.addr",  128'(exp_addr),           128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // 1: all match, back-to-back.
    run("s1", 0, -1);
    check_results("s1");
    sig_ref = signature;

    // 2: single fault at vector 5; signature depends on responses only.
    rom[5][0] = ~rom[5][0];
    run("s2", 0, -1);
    check_results("s2");
    check("s2.sig_eq_s1", 128'(signature), 128'(sig_ref));
    check("s2.ffi5",      128'(first_fail_idx), 128'(5));
    rom[5] = resp[5];

    // 3: two-cycle stalls between beats.
    run("s3", 2, -1);
    check_results("s3");
    check("s3.sig_eq_s1", 128'(signature), 128'(sig_ref));

    // 5: reset after four beats of a fresh run.
    for (int v = 0; v < NV; v++) begin
      resp[v] = rand_vec();
      rom[v]  = resp[v];
    end
    do_start();
    for (int i = 0; i < 4; i++) beat(i, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("s5.flags", 128'({busy, done, pass}), 128'(3'b000));
    check("s5.cnt",   128'(sat_cnt),            128'(0));
    check("s5.sig",   128'(signature),          128'(SEED));
    check("s5.addr",  128'(exp_addr),           128'(0));
    rst_n = 1'b1;
    @(negedge clk);
    rom[3] = rand_vec();
    run("s5run", $urandom_range(0, 2), -1);
    check_results("s5run");

    // 6: start pulsed mid-run is ignored, then resp_valid in DONE is ignored.
    for (int v = 0; v < NV; v++) begin
      resp[v] = rand_vec();
      rom[v]  = (v == 1 || v == 4) ? rand_vec() : resp[v];
    end
    run("s6", 1, 3);
    check_results("s6");
    for (int k = 0; k < 3; k++) begin
      resp_valid = 1'b1;
      resp_vec   = rand_vec();
      @(negedge clk);
    end
    resp_valid = 1'b0;
    check("s6.still_done", 128'({busy, done}), 128'(2'b01));
    check_results("s6.after_valid");

    // 6b: restart from DONE clears the previous results.
    do_start();
    check("s6b.flags", 128'({busy, done, pass}), 128'(3'b100));
    check("s6b.cnt",   128'(mismatch_cnt),       128'(0));
    check("s6b.ffi",   128'(first_fail_idx),     128'(0));
    check("s6b.sig",   128'(signature),          128'(SEED));
    for (int v = 0; v < NV; v++) begin
      resp[v] = rand_vec();
      rom[v]  = (v == 2 || v == 6) ? ~resp[v] : resp[v];
    end
    for (int i = 0; i < NV; i++) beat(i, 1'b0);
    @(negedge clk);
    check("s6b.done", 128'(done), 128'(1));
    check_results("s6b");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
